// File: rtl/addsub_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
// Provides the FSM state type and the saturation constant builder.
package addsub_pkg;

    localparam int MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturation value for a given width:
    // neg = 0 -> 0x7F..F, neg = 1 -> 0x80..0.
    function automatic logic [MAX_W-1:0] sat_value(
        input int   width,
        input logic neg
    );
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width - 1) begin
                v[i] = ~neg;
            end else if (i == width - 1) begin
                v[i] = neg;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple adder built from 1-bit full adders.
// Ports: a, b, cin -> s, cout, c_msb_in (carry into top bit).
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per cycle, LSB first.
// Ports: in_valid/in_ready + A,B,sub,sat; out_valid/out_ready + Sum,Ovfl,Cout,Zero,Neg.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Cout,
    output logic             Zero,
    output logic             Neg
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   step;
    logic   last;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_msb_q;
    logic             sat_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] sum_q;
    logic             ovfl_q;
    logic             cout_q;
    logic             zero_q;
    logic             neg_q;

    logic [CHUNK-1:0] ch_s;
    logic             ch_cout;
    logic             ch_cmsb;

    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_fin;
    logic [WIDTH-1:0] sat_v;
    logic             ovfl_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands shift right so the active chunk is always at the bottom.
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_q[CHUNK-1:0]),
        .b        (b_q[CHUNK-1:0]),
        .cin      (carry_q),
        .s        (ch_s),
        .cout     (ch_cout),
        .c_msb_in (ch_cmsb)
    );

    // Completed low chunks; the final chunk joins combinationally.
    if (NCHUNK > 1) begin : g_acc
        logic [WIDTH-CHUNK-1:0] acc_q;
        logic [WIDTH-1:0]       acc_w;

        assign acc_w   = {ch_s, acc_q};
        assign sum_raw = acc_w;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q <= '0;
            end else if (accept) begin
                acc_q <= '0;
            end else if (step) begin
                acc_q <= acc_w[WIDTH-1:CHUNK];
            end
        end
    end else begin : g_noacc
        assign sum_raw = ch_s;
    end

    assign ovfl_raw = ch_cmsb ^ ch_cout;
    assign sat_v    = WIDTH'(sat_value(WIDTH, a_msb_q));
    assign sum_fin  = (sat_q && ovfl_raw) ? sat_v : sum_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            sat_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B ^ {WIDTH{sub}};
            a_msb_q <= A[WIDTH-1];
            sat_q   <= sat;
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= ch_cout;
            cnt_q   <= last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            ovfl_q <= 1'b0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (last) begin
            sum_q  <= sum_fin;
            ovfl_q <= ovfl_raw;
            cout_q <= ch_cout;
            zero_q <= (sum_fin == '0);
            neg_q  <= sum_fin[WIDTH-1];
        end
    end

    assign Sum  = sum_q;
    assign Ovfl = ovfl_q;
    assign Cout = cout_q;
    assign Zero = zero_q;
    assign Neg  = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed vectors, arithmetic model, scoreboard.
// Also checks a WIDTH=CHUNK=16 instance for single-step latency.
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        Ovfl;
    logic        Cout;
    logic        Zero;
    logic        Neg;

    logic        in_valid1;
    logic        in_ready1;
    logic [15:0] A1;
    logic [15:0] B1;
    logic        sub1;
    logic        sat1;
    logic        out_valid1;
    logic        out_ready1;
    logic [15:0] Sum1;
    logic        Ovfl1;
    logic        Cout1;
    logic        Zero1;
    logic        Neg1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        o;
        logic        c;
        logic        z;
        logic        n;
    } res_t;

    res_t q[$];

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Ovfl      (Ovfl),
        .Cout      (Cout),
        .Zero      (Zero),
        .Neg       (Neg)
    );

    addsub_seq #(.WIDTH(16), .CHUNK(16)) u_wide (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .A         (A1),
        .B         (B1),
        .sub       (sub1),
        .sat       (sat1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .Sum       (Sum1),
        .Ovfl      (Ovfl1),
        .Cout      (Cout1),
        .Zero      (Zero1),
        .Neg       (Neg1)
    );

    function automatic res_t model(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        s,
        input logic        st
    );
        int   sa;
        int   sb;
        int   r;
        int   ua;
        int   ub;
        res_t e;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        ua  = int'(a);
        ub  = int'(b);
        r   = s ? sa - sb : sa + sb;
        e.o = (r > 32767) || (r < -32768);
        e.c = s ? (ua >= ub) : ((ua + ub) > 65535);
        if (st && e.o) begin
            e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
        end else begin
            e.sum = r[15:0];
        end
        e.z = (e.sum == 16'h0000);
        e.n = e.sum[15];
        return e;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("cmp_unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("cmp_result", 32'({Sum, Ovfl, Cout, Zero, Neg}),
                    32'(q[0]));
                if (out_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic do_op(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        s,
        input logic        st,
        input logic [19:0] lit,
        input string       nm
    );
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        sub      = s;
        sat      = st;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(a, b, s, st));
        in_valid = 1'b0;
        A        = 16'hDEAD;
        B        = 16'hBEEF;
        sub      = ~s;
        sat      = ~st;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd4);
        chk({nm, "_lit"}, 32'({Sum, Ovfl, Cout, Zero, Neg}), 32'(lit));
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({nm, "_ovalid_drop"}, 32'(out_valid), 32'd0);
            chk({nm, "_iready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        sub        = 1'b0;
        sat        = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        A1         = '0;
        B1         = '0;
        sub1       = 1'b0;
        sat1       = 1'b0;
        out_ready1 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            32'({in_ready, out_valid, Sum, Ovfl, Cout, Zero, Neg}), 32'd0);
        chk("reset_wide_outputs",
            32'({in_ready1, out_valid1, Sum1, Ovfl1, Cout1, Zero1, Neg1}),
            32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_release_iready", 32'(in_ready), 32'd1);

        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, {16'h2345, 4'b0000}, "add");
        do_op(16'h0005, 16'h0005, 1'b1, 1'b0, {16'h0000, 4'b0110}, "subz");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b1001}, "povf");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 4'b1000}, "povfs");
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 4'b1100}, "novf");
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 4'b1101}, "novfs");
        do_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b1, {16'h0000, 4'b0110}, "wrap0");

        out_ready = 1'b0;
        do_op(16'h00FF, 16'h0100, 1'b1, 1'b0, {16'hFFFF, 4'b0001}, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            A        = 16'(i * 16'h1111);
            B        = 16'h0003;
            @(posedge clk);
            #1;
            chk("bp_ovalid", 32'(out_valid), 32'd1);
            chk("bp_iready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'({Sum, Ovfl, Cout, Zero, Neg}),
                32'({16'hFFFF, 4'b0001}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ovalid", 32'(out_valid), 32'd0);
        chk("bp_release_iready", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_no_ghost_op", 32'(out_valid), 32'd0);

        A1        = 16'h7FFF;
        B1        = 16'h0001;
        sub1      = 1'b0;
        sat1      = 1'b1;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wide_latency", 32'(n), 32'd1);
        chk("wide_lit", 32'({Sum1, Ovfl1, Cout1, Zero1, Neg1}),
            32'({16'h7FFF, 4'b1000}));
        @(posedge clk);
        #1;
        chk("wide_iready_back", 32'(in_ready1), 32'd1);

        A        = 16'h1234;
        B        = 16'h0001;
        sub      = 1'b0;
        sat      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(16'h1234, 16'h0001, 1'b0, 1'b0));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_outputs",
            32'({in_ready, out_valid, Sum, Ovfl, Cout, Zero, Neg}), 32'd0);
        chk("midrst_wide_sum", 32'(Sum1), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_iready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 4'b0110}, "postrst");

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle adder/subtractor with valid/ready handshakes on both sides. It processes a WIDTH-bit two's-complement add or subtract CHUNK bits per cycle, LSB chunk first. It reports overflow, carry, zero and negative flags, and can optionally saturate on overflow. It is the datapath-width successor to the 4-bit add/sub in the ALU and is used wherever a 16-bit or wider add/sub can tolerate multi-cycle latency in exchange for a short carry chain.

## Interface
- WIDTH, 16: operand/result width in bits. Must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 4: bits resolved per cycle. NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock. All state changes on the rising edge.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept. High only in IDLE with rst_n high.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- sub  input  1  0 = A+B, 1 = A−B.
- sat  input  1  1 = saturate the result on signed overflow.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- Sum  output  WIDTH  result, possibly saturated.
- Ovfl  output  1  signed overflow of the unsaturated result.
- Cout  output  1  carry out of the MSB. For sub, 1 means no borrow.
- Zero  output  1  Sum == 0 after saturation.
- Neg  output  1  Sum[WIDTH-1] after saturation.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY on in_valid && in_ready.
  - At that edge, capture A, B^{WIDTH{sub}}, sub and sat.
  - Set the carry register to sub, so subtraction is A + ~B + 1.
  - Clear the chunk counter.
- BUSY:
  - Each cycle, add chunk[cnt] of A and B' with the carry register.
  - Write the CHUNK result bits into the Sum shift/accumulate register.
  - Update the carry and increment cnt.
  - On the cycle with cnt == NCHUNK-1, go to DONE and register the flags.
- Flag computation at the final chunk:
  - Ovfl = carry into MSB ^ carry out of MSB.
  - Cout = carry out of MSB.
- Saturation applies when sat && Ovfl:
  - Sum = 0x7F..F if captured A[MSB] == 0.
  - Sum = 0x80..0 if captured A[MSB] == 1.
  - Ovfl stays 1.
  - With sat == 0, Sum wraps.
- Zero and Neg are derived from the final, post-saturation Sum.
- DONE:
  - out_valid = 1. Sum and flags are held stable.
  - DONE → IDLE on out_ready.
- Sum and flags keep the last result after leaving DONE until the next completion.
- in_valid outside IDLE is ignored. No operation is queued.

## Timing
- Reset (rst_n low at an edge):
  - State = IDLE, cnt = 0, carry = 0.
  - Sum = 0, Ovfl = Cout = Zero = Neg = 0, out_valid = 0.
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after release.
- Latency: if the accept handshake occurs at edge E, out_valid is high in the cycle after edge E+NCHUNK. When CHUNK == WIDTH, out_valid is high in the cycle after E+1.
- Throughput: one operation per NCHUNK+2 cycles at best.
  - The out_ready handshake at edge F returns the block to IDLE.
  - in_ready is high in the cycle after F.
- Backpressure: out_valid stays high, and Sum/flags stay unchanged, for as long as out_ready is low. in_ready stays 0.
- Reset mid-operation (BUSY or DONE): the operation is aborted and no out_valid is produced. Outputs follow the reset values.
- Operand inputs are sampled only at the accept edge. Changing A, B, sub or sat during BUSY has no effect.
- cnt width is max(1, $clog2(NCHUNK)).
- cnt wraps to 0 on the BUSY → DONE edge.

## Structure
- Package addsub_pkg holds:
  - the state enum typedef (IDLE, BUSY, DONE);
  - a function returning the saturation constants for a given width.
- Sub-module addsub_chunk is a CHUNK-bit ripple adder built from full_adder_1bit.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb_in (carry into its top bit, used for Ovfl on the last chunk).
- The top module holds the FSM, counter, operand registers and result/flag registers.

## Test plan
Defaults are WIDTH=16 and CHUNK=4, with out_ready held high unless stated.

1. Add: 0x1234 + 0x1111, sub=0, sat=0.
   - out_valid rises 4 edges after accept.
   - Sum=0x2345, Ovfl=0, Cout=0, Zero=0, Neg=0.
2. Subtract to zero: 0x0005 − 0x0005.
   - Sum=0x0000, Zero=1, Cout=1, Ovfl=0, Neg=0.
3. Positive overflow: 0x7FFF + 0x0001.
   - With sat=0: Sum=0x8000, Ovfl=1, Neg=1.
   - With sat=1: Sum=0x7FFF, Ovfl=1, Neg=0.
4. Negative overflow: 0x8000 − 0x0001.
   - With sat=0: Sum=0x7FFF, Ovfl=1, Cout=1.
   - With sat=1: Sum=0x8000, Ovfl=1, Neg=1.
5. Backpressure and accept rules:
   - out_ready low for 5 cycles in DONE: out_valid, Sum and flags are stable and in_ready=0. in_valid pulses in that window are ignored.
   - After out_ready goes high, in_ready is 1 in the next cycle.
   - With WIDTH=CHUNK=16, latency is 1 edge.
6. Reset mid-operation:
   - rst_n low during the second BUSY cycle: no out_valid, all outputs 0.
   - in_ready=1 in the first cycle after release.
   - A following 0xFFFF + 0x0001 gives Sum=0x0000, Cout=1, Zero=1, Ovfl=0.
